// File: rtl/calc_port_if.sv
// Calculator port bundle: two-cycle request in, tagged one-cycle response out.
// Bit 0 is the MSB of every bus.
interface calc_port_if;
   logic [0:3]  req_cmd;
   logic [0:31] req_data_in;
   logic [0:1]  req_tag;
   logic [0:1]  out_resp;
   logic [0:31] out_data;
   logic [0:1]  out_tag;
   logic        proto_err;

   modport master (
      output req_cmd, req_data_in, req_tag,
      input  out_resp, out_data, out_tag, proto_err
   );
   modport slave (
      input  req_cmd, req_data_in, req_tag,
      output out_resp, out_data, out_tag, proto_err
   );
endinterface

// File: rtl/calc_port_responder.sv
// Calculator port responder: captures cmd/tag/op1 then op2, executes add/sub/shift,
// and returns a tagged response LATENCY edges after the operand-2 edge.
module calc_port_responder #(
   parameter int LATENCY = 3
) (
   input  logic       c_clk,
   input  logic       reset,
   calc_port_if.slave cp
);
   localparam logic [3:0] CMD_ADD  = 4'd1;
   localparam logic [3:0] CMD_SUB  = 4'd2;
   localparam logic [3:0] CMD_SHL  = 4'd5;
   localparam logic [3:0] CMD_SHR  = 4'd6;
   localparam logic [1:0] RSP_OK   = 2'd1;
   localparam logic [1:0] RSP_ERR  = 2'd2;
   localparam logic [1:0] RSP_COLL = 2'd3;

   typedef enum logic {IDLE, OP2} state_t;
   typedef struct packed {
      logic [1:0]  resp;
      logic [31:0] data;
      logic [1:0]  tag;
   } rsp_t;

   state_t             state_q, state_d;
   logic [3:0]         cmd_q;
   logic [1:0]         tag_q;
   logic [31:0]        op1_q, op2;
   logic [32:0]        sum;
   logic [3:0]         busy_q, busy_eff, clr_mask, set_mask;
   logic               proto_err_q, capture, issue;
   rsp_t               res;
   rsp_t               pipe [LATENCY];
   logic [LATENCY-1:0] vld_pipe;

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      issue   = 1'b0;
      case (state_q)
         IDLE: if (cp.req_cmd != 4'd0) begin
            capture = 1'b1;
            state_d = OP2;
         end
         OP2: begin
            issue   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A response leaving the last stage frees its tag on the edge that ends its
   // cycle; collision responses never owned the tag, so they leave busy alone.
   always_comb begin
      clr_mask = '0;
      if (vld_pipe[LATENCY-1] && pipe[LATENCY-1].resp != RSP_COLL)
         clr_mask[pipe[LATENCY-1].tag] = 1'b1;
      busy_eff = busy_q & ~clr_mask;
   end

   always_comb begin
      op2      = cp.req_data_in;
      sum      = {1'b0, op1_q} + {1'b0, op2};
      res      = '0;
      res.tag  = tag_q;
      set_mask = '0;
      if (busy_eff[tag_q]) begin
         res.resp = RSP_COLL;
      end else begin
         res.resp = RSP_ERR;
         case (cmd_q)
            CMD_ADD: if (!sum[32]) begin
               res.resp = RSP_OK;
               res.data = sum[31:0];
            end
            CMD_SUB: if (op2 <= op1_q) begin
               res.resp = RSP_OK;
               res.data = op1_q - op2;
            end
            CMD_SHL: begin
               res.resp = RSP_OK;
               res.data = op1_q << op2[4:0];
            end
            CMD_SHR: begin
               res.resp = RSP_OK;
               res.data = op1_q >> op2[4:0];
            end
            default: ;
         endcase
         if (issue) set_mask[tag_q] = 1'b1;
      end
   end

   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         tag_q       <= '0;
         op1_q       <= '0;
         busy_q      <= '0;
         proto_err_q <= 1'b0;
         vld_pipe    <= '0;
         for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            cmd_q <= cp.req_cmd;
            tag_q <= cp.req_tag;
            op1_q <= cp.req_data_in;
         end
         if (issue && cp.req_cmd != 4'd0) proto_err_q <= 1'b1;
         busy_q      <= busy_eff | set_mask;
         vld_pipe[0] <= issue;
         pipe[0]     <= issue ? res : '0;
         for (int i = 1; i < LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            pipe[i]     <= pipe[i-1];
         end
      end
   end

   // Idle stages hold zeros, so the last stage drives the outputs directly.
   assign cp.out_resp  = pipe[LATENCY-1].resp;
   assign cp.out_data  = pipe[LATENCY-1].data;
   assign cp.out_tag   = pipe[LATENCY-1].tag;
   assign cp.proto_err = proto_err_q;
endmodule
